rpn_stack_sequencer: RTL and testbench
======================================

Name: rpn_stack_sequencer

Overview:
Command-driven controller that owns the calculator's operand stack RAM and stack pointer. It accepts one RPN command at a time over a valid/ready handshake: push, pop, add, sub, mul, dup, clear. It sequences the RAM reads and writes each command needs, applies the arithmetic, and keeps a top-of-stack (TOS) mirror and depth count for the LED/HEX display logic. It sits between the key/switch front-end and the single-port stack RAM.

Parameters:
DATA_W, 8, operand/RAM word width
ADDR_W, 5, RAM address width; stack capacity DEPTH = 2**ADDR_W entries

Ports:
CLOCK_50  in  1  system clock, all logic on rising edge
reset_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  controller can accept a command (high only in IDLE)
cmd_op  in  3  0 PUSH, 1 POP, 2 ADD, 3 SUB, 4 MUL, 5 DUP, 6 CLEAR, 7 illegal
cmd_data  in  DATA_W  operand for PUSH, ignored otherwise
done  out  1  one-cycle pulse, command finished
err  out  2  valid with done: 00 ok, 01 underflow, 10 overflow, 11 illegal op
tos  out  DATA_W  current top of stack; 0 when empty
depth  out  ADDR_W+1  number of entries on the stack, 0..DEPTH
mem_addr  out  ADDR_W  stack RAM address
mem_we  out  1  stack RAM write enable
mem_wdata  out  DATA_W  stack RAM write data
mem_rdata  in  DATA_W  stack RAM read data; valid one cycle after mem_addr is presented (synchronous read)

Behaviour:
- Reset (async, reset_n low):
  - State goes to IDLE. depth=0, tos=0, done=0, err=00, mem_we=0, mem_addr=0, mem_wdata=0, cmd_ready is high after release.
  - Reset mid-command abandons the command, with no done pulse. RAM contents are undefined but unused.
- Stack layout: entry i (0 = bottom) lives at address i. The next free address is depth. The tos register always mirrors mem[depth-1].
- States: IDLE, WRITE, READ, EXEC, DONE.
  - Handshake: a command is accepted at the edge where cmd_valid & cmd_ready. Call that edge T, so T+1 is the first cycle after acceptance. cmd_op and cmd_data are latched at T.
  - cmd_ready is low in every non-IDLE state. cmd_valid is ignored while busy.
- Error checks happen at acceptance. On error, go to DONE at T+1 with the err code. Stack, tos, depth and RAM are unchanged and mem_we stays 0.
  - underflow: POP with depth<1; ADD/SUB/MUL with depth<2; DUP with depth=0.
  - overflow: PUSH or DUP with depth=DEPTH.
  - illegal: op 7.
- PUSH and DUP:
  - WRITE at T+1: mem_addr=depth, mem_we=1, mem_wdata=cmd_data (PUSH) or tos (DUP).
  - At end of WRITE: depth+1, tos<=written value.
  - DONE at T+2.
- POP:
  - depth=1: depth<=0, tos<=0, DONE at T+1.
  - Else READ at T+1 with mem_addr=depth-2, mem_we=0.
  - EXEC at T+2: tos<=mem_rdata, depth-1.
  - DONE at T+3.
- ADD/SUB/MUL (a = mem[depth-2], b = tos):
  - READ at T+1 with mem_addr=depth-2.
  - EXEC at T+2: r = a+b, a-b, or low DATA_W bits of a*b. Modulo 2**DATA_W, no overflow flag. Write mem_addr=depth-2, mem_we=1, mem_wdata=r. At end of cycle tos<=r, depth-1.
  - DONE at T+3.
- CLEAR: depth<=0, tos<=0, DONE at T+1. RAM is not scrubbed.
- DONE lasts exactly one cycle: done=1 with err valid, then IDLE. err holds its value until the next done.
- mem_we is high only in WRITE and in EXEC for arithmetic ops. At every other time mem_we=0 and mem_wdata is don't-care.
- A back-to-back cmd_valid held high is accepted in the IDLE cycle right after DONE.

Test Plan:
- Reset then PUSH 0x03, PUSH 0x05 -> two done pulses err=00, 2 cycles after each accept; depth=2, tos=0x05, mem[0]=0x03, mem[1]=0x05.
- Continue with SUB -> done at T+3, err=00, tos=0xFE, depth=1, mem[0]=0xFE. Then PUSH 0x10, MUL -> tos=0xE0 (0xFE*0x10 low byte), depth=1.
- POP on depth=1 -> tos=0, depth=0, done at T+1. POP again -> err=01, depth=0. ADD with depth=1 -> err=01, stack unchanged.
- Fill with 32 PUSHes (values 0..31), then PUSH 0xAA -> err=10, depth=32, tos=31. DUP -> err=10. POP -> tos=30, depth=31, done at T+3.
- DUP on tos=0x07 -> depth+1, tos=0x07, mem[depth-1]=0x07. op 7 -> err=11, no state change. CLEAR -> depth=0, tos=0.
- Assert reset_n low during EXEC of ADD -> immediately depth=0, tos=0, mem_we=0, no done. After release cmd_ready=1 and PUSH 0x01 gives tos=0x01, depth=1.

Source files
------------

// File: rtl/rpn_stack_sequencer.sv
// RPN stack controller: accepts one command at a time, sequences the single-port
// stack RAM, and keeps a top-of-stack mirror and depth count for the display.
module rpn_stack_sequencer #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5
) (
  input  logic              CLOCK_50,
  input  logic              reset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              done,
  output logic [1:0]        err,
  output logic [DATA_W-1:0] tos,
  output logic [ADDR_W:0]   depth,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] FULL = DEPTH[ADDR_W:0];

  localparam logic [2:0] OP_PUSH  = 3'd0;
  localparam logic [2:0] OP_POP   = 3'd1;
  localparam logic [2:0] OP_ADD   = 3'd2;
  localparam logic [2:0] OP_SUB   = 3'd3;
  localparam logic [2:0] OP_MUL   = 3'd4;
  localparam logic [2:0] OP_DUP   = 3'd5;
  localparam logic [2:0] OP_CLEAR = 3'd6;

  localparam logic [1:0] ERR_OK    = 2'b00;
  localparam logic [1:0] ERR_UNDER = 2'b01;
  localparam logic [1:0] ERR_OVER  = 2'b10;
  localparam logic [1:0] ERR_ILL   = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WRITE = 3'd1,
    S_READ  = 3'd2,
    S_EXEC  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t            state_reg, state_next;
  logic [2:0]        op_reg, op_next;
  logic [DATA_W-1:0] data_reg, data_next;
  logic [DATA_W-1:0] tos_reg, tos_next;
  logic [ADDR_W:0]   depth_reg, depth_next;
  logic [1:0]        err_reg, err_next;

  logic [ADDR_W-1:0] addr_top;
  logic [ADDR_W-1:0] addr_below;
  logic [ADDR_W:0]   depth_dec;
  logic [DATA_W-1:0] sum, diff, prod, arith;

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= S_IDLE;
      op_reg    <= '0;
      data_reg  <= '0;
      tos_reg   <= '0;
      depth_reg <= '0;
      err_reg   <= ERR_OK;
    end else begin
      state_reg <= state_next;
      op_reg    <= op_next;
      data_reg  <= data_next;
      tos_reg   <= tos_next;
      depth_reg <= depth_next;
      err_reg   <= err_next;
    end
  end

  // Next free slot is depth; the second-from-top entry (operand a / new top after POP) is depth-2.
  assign addr_top   = depth_reg[ADDR_W-1:0];
  assign addr_below = depth_reg[ADDR_W-1:0] - ADDR_W'(2);
  assign depth_dec  = depth_reg - (ADDR_W+1)'(1);

  // a comes from RAM (mem[depth-2]), b is the TOS mirror; results wrap modulo 2**DATA_W.
  assign sum  = mem_rdata + tos_reg;
  assign diff = mem_rdata - tos_reg;
  assign prod = mem_rdata * tos_reg;

  always_comb begin
    arith = sum;
    case (op_reg)
      OP_SUB:  arith = diff;
      OP_MUL:  arith = prod;
      default: arith = sum;
    endcase
  end

  always_comb begin
    state_next = state_reg;
    op_next    = op_reg;
    data_next  = data_reg;
    tos_next   = tos_reg;
    depth_next = depth_reg;
    err_next   = err_reg;
    mem_addr   = '0;
    mem_we     = 1'b0;
    mem_wdata  = '0;

    case (state_reg)
      S_IDLE: begin
        if (cmd_valid) begin
          op_next   = cmd_op;
          data_next = cmd_data;
          case (cmd_op)
            OP_PUSH, OP_DUP: begin
              if (depth_reg == FULL) begin
                err_next   = ERR_OVER;
                state_next = S_DONE;
              end else if (cmd_op == OP_DUP && depth_reg == '0) begin
                err_next   = ERR_UNDER;
                state_next = S_DONE;
              end else begin
                state_next = S_WRITE;
              end
            end
            OP_POP: begin
              if (depth_reg == '0) begin
                err_next   = ERR_UNDER;
                state_next = S_DONE;
              end else if (depth_reg == (ADDR_W+1)'(1)) begin
                // Last entry leaves: nothing below it to fetch.
                depth_next = '0;
                tos_next   = '0;
                err_next   = ERR_OK;
                state_next = S_DONE;
              end else begin
                state_next = S_READ;
              end
            end
            OP_ADD, OP_SUB, OP_MUL: begin
              if (depth_reg < (ADDR_W+1)'(2)) begin
                err_next   = ERR_UNDER;
                state_next = S_DONE;
              end else begin
                state_next = S_READ;
              end
            end
            OP_CLEAR: begin
              depth_next = '0;
              tos_next   = '0;
              err_next   = ERR_OK;
              state_next = S_DONE;
            end
            default: begin
              err_next   = ERR_ILL;
              state_next = S_DONE;
            end
          endcase
        end
      end

      S_WRITE: begin
        mem_addr   = addr_top;
        mem_we     = 1'b1;
        mem_wdata  = (op_reg == OP_DUP) ? tos_reg : data_reg;
        tos_next   = mem_wdata;
        depth_next = depth_reg + (ADDR_W+1)'(1);
        err_next   = ERR_OK;
        state_next = S_DONE;
      end

      S_READ: begin
        mem_addr   = addr_below;
        state_next = S_EXEC;
      end

      S_EXEC: begin
        mem_addr   = addr_below;
        depth_next = depth_dec;
        err_next   = ERR_OK;
        state_next = S_DONE;
        if (op_reg == OP_POP) begin
          tos_next = mem_rdata;
        end else begin
          mem_we    = 1'b1;
          mem_wdata = arith;
          tos_next  = arith;
        end
      end

      S_DONE: begin
        state_next = S_IDLE;
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  assign cmd_ready = (state_reg == S_IDLE);
  assign done      = (state_reg == S_DONE);
  assign err       = err_reg;
  assign tos       = tos_reg;
  assign depth     = depth_reg;

endmodule

// File: tb/tb_rpn_stack_sequencer.sv
// Directed bench for rpn_stack_sequencer with a synchronous-read stack RAM model.
module tb_rpn_stack_sequencer;

  logic       CLOCK_50;
  logic       reset_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [7:0] cmd_data;
  logic       done;
  logic [1:0] err;
  logic [7:0] tos;
  logic [5:0] depth;
  logic [4:0] mem_addr;
  logic       mem_we;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;

  logic [7:0] ram [0:31];

  int checks = 0;
  int fails  = 0;

  rpn_stack_sequencer #(.DATA_W(8), .ADDR_W(5)) dut (
    .CLOCK_50  (CLOCK_50),
    .reset_n   (reset_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_data  (cmd_data),
    .done      (done),
    .err       (err),
    .tos       (tos),
    .depth     (depth),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  initial CLOCK_50 = 1'b0;
  always #10 CLOCK_50 = ~CLOCK_50;

  always @(posedge CLOCK_50) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic [7:0] d);
    int guard;
    guard = 0;
    @(negedge CLOCK_50);
    while (!cmd_ready && guard < 20) begin
      @(negedge CLOCK_50);
      guard++;
    end
    chk("ready_before_issue", {31'd0, cmd_ready}, 32'd1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = d;
    @(posedge CLOCK_50);
    #1;
    cmd_valid = 1'b0;
  endtask

  // Called #1 after the acceptance edge; latency 1 means done in the first cycle after it.
  task automatic wait_done(input string tag, input int exp_lat, input logic [1:0] exp_err);
    int lat;
    lat = 1;
    while (!done && lat < 16) begin
      @(posedge CLOCK_50);
      #1;
      lat++;
    end
    chk({tag, "_done"}, {31'd0, done}, 32'd1);
    chk({tag, "_lat"}, lat, exp_lat);
    chk({tag, "_err"}, {30'd0, err}, {30'd0, exp_err});
    $display("cmd %s: latency=%0d err=%0d depth=%0d tos=0x%02h", tag, lat, err, depth, tos);
  endtask

  initial begin
    reset_n   = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = 3'd0;
    cmd_data  = 8'd0;
    repeat (3) @(posedge CLOCK_50);
    #1;
    chk("rst_depth", depth, 0);
    chk("rst_tos", tos, 0);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_err", {30'd0, err}, 0);
    chk("rst_we", {31'd0, mem_we}, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    @(negedge CLOCK_50);
    reset_n = 1'b1;
    @(posedge CLOCK_50);
    #1;
    chk("rst_ready", {31'd0, cmd_ready}, 1);

    // PUSH 0x03: check the WRITE-cycle RAM port, then completion
    issue(3'd0, 8'h03);
    chk("push3_we", {31'd0, mem_we}, 1);
    chk("push3_addr", mem_addr, 0);
    chk("push3_wdata", mem_wdata, 8'h03);
    chk("push3_ready_busy", {31'd0, cmd_ready}, 0);
    wait_done("push3", 2, 2'b00);
    issue(3'd0, 8'h05);
    wait_done("push5", 2, 2'b00);
    chk("p2_depth", depth, 2);
    chk("p2_tos", tos, 8'h05);
    chk("p2_mem0", ram[0], 8'h03);
    chk("p2_mem1", ram[1], 8'h05);

    issue(3'd3, 8'h00);
    wait_done("sub", 3, 2'b00);
    chk("sub_tos", tos, 8'hFE);
    chk("sub_depth", depth, 1);
    chk("sub_mem0", ram[0], 8'hFE);

    issue(3'd0, 8'h10);
    wait_done("push10", 2, 2'b00);
    issue(3'd4, 8'h00);
    wait_done("mul", 3, 2'b00);
    chk("mul_tos", tos, 8'hE0);
    chk("mul_depth", depth, 1);
    chk("mul_mem0", ram[0], 8'hE0);

    issue(3'd1, 8'h00);
    wait_done("pop_last", 1, 2'b00);
    chk("pop_last_tos", tos, 0);
    chk("pop_last_depth", depth, 0);
    issue(3'd1, 8'h00);
    wait_done("pop_empty", 1, 2'b01);
    chk("pop_empty_depth", depth, 0);
    @(posedge CLOCK_50);
    #1;
    chk("done_one_cycle", {31'd0, done}, 0);
    chk("err_held", {30'd0, err}, 32'd1);

    issue(3'd0, 8'h07);
    wait_done("push7", 2, 2'b00);
    issue(3'd2, 8'h00);
    wait_done("add_under", 1, 2'b01);
    chk("add_under_depth", depth, 1);
    chk("add_under_tos", tos, 8'h07);
    issue(3'd6, 8'h00);
    wait_done("clear1", 1, 2'b00);

    for (int i = 0; i < 32; i++) begin
      issue(3'd0, 8'(i));
      wait_done("fill", 2, 2'b00);
    end
    chk("full_depth", depth, 32);
    chk("full_tos", tos, 31);
    chk("full_mem31", ram[31], 31);
    issue(3'd0, 8'hAA);
    wait_done("push_over", 1, 2'b10);
    chk("push_over_depth", depth, 32);
    chk("push_over_tos", tos, 31);
    issue(3'd5, 8'h00);
    wait_done("dup_over", 1, 2'b10);
    issue(3'd1, 8'h00);
    wait_done("pop_full", 3, 2'b00);
    chk("pop_full_tos", tos, 30);
    chk("pop_full_depth", depth, 31);

    issue(3'd6, 8'h00);
    wait_done("clear2", 1, 2'b00);
    issue(3'd5, 8'h00);
    wait_done("dup_empty", 1, 2'b01);
    issue(3'd0, 8'h07);
    wait_done("push7b", 2, 2'b00);
    issue(3'd5, 8'h00);
    chk("dup_wdata", mem_wdata, 8'h07);
    chk("dup_addr", mem_addr, 1);
    wait_done("dup", 2, 2'b00);
    chk("dup_depth", depth, 2);
    chk("dup_tos", tos, 8'h07);
    chk("dup_mem1", ram[1], 8'h07);
    issue(3'd7, 8'h00);
    wait_done("illegal", 1, 2'b11);
    chk("illegal_depth", depth, 2);
    chk("illegal_tos", tos, 8'h07);
    issue(3'd6, 8'h00);
    wait_done("clear3", 1, 2'b00);
    chk("clear3_depth", depth, 0);
    chk("clear3_tos", tos, 0);

    // Reset while the ADD is in EXEC must abandon it silently
    issue(3'd0, 8'h01);
    wait_done("pushr1", 2, 2'b00);
    issue(3'd0, 8'h02);
    wait_done("pushr2", 2, 2'b00);
    issue(3'd2, 8'h00);
    @(posedge CLOCK_50);
    #1;
    chk("exec_we", {31'd0, mem_we}, 1);
    reset_n = 1'b0;
    #1;
    chk("abort_depth", depth, 0);
    chk("abort_tos", tos, 0);
    chk("abort_we", {31'd0, mem_we}, 0);
    chk("abort_done", {31'd0, done}, 0);
    repeat (2) begin
      @(posedge CLOCK_50);
      #1;
      chk("abort_no_done", {31'd0, done}, 0);
    end
    @(negedge CLOCK_50);
    reset_n = 1'b1;
    @(posedge CLOCK_50);
    #1;
    chk("abort_ready", {31'd0, cmd_ready}, 1);
    chk("abort_still_no_done", {31'd0, done}, 0);
    issue(3'd0, 8'h01);
    wait_done("push_after_rst", 2, 2'b00);
    chk("after_rst_tos", tos, 8'h01);
    chk("after_rst_depth", depth, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
